rv_ifetch: RTL and testbench

//  Instruction-fetch front end. Consumes the next-PC value produced by the

---
 rtl/rv_ifetch_pkg.sv | 19 +
 rtl/rv_ifetch_fifo.sv | 54 +++++
 rtl/rv_ifetch.sv | 134 +++++++++++++
 tb/tb_rv_ifetch.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ifetch_pkg.sv
// rtl/rv_ifetch_pkg.sv - shared types and constants for the instruction-fetch front end
package rv_ifetch_pkg;

   localparam int DATA_WIDTH = 32;
   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_BOOT,
      S_RUN,
      S_HALT
   } ifetch_state_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] pc;
      logic [31:0]           instr;
      logic                  trap;
   } if_entry_t;

endpackage

// File: rtl/rv_ifetch_fifo.sv
// rtl/rv_ifetch_fifo.sv - synchronous FIFO with flush and occupancy count
module rv_ifetch_fifo
   import rv_ifetch_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter type T = if_entry_t
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic                        push,
   input  T                            push_data,
   input  logic                        pop,
   output T                            head,
   output logic [$clog2(FIFO_DEPTH):0] count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   T               mem [FIFO_DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  wr_idx;

   // A push alongside a flush becomes the sole entry, written at slot 0.
   assign wr_idx = flush ? '0 : wr_ptr;
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= AW'(push);
         count  <= CW'(push);
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_idx] <= push_data;
   end

endmodule

// File: rtl/rv_ifetch.sv
// rtl/rv_ifetch.sv - instruction fetch front end; RV_IFETCH_MISALIGN_TRAP_EN adds if_trap and S_HALT
module rv_ifetch
   import rv_ifetch_pkg::*;
#(
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
   parameter int                    FIFO_DEPTH = 2,
   parameter int                    MAX_OUTST  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  redirect_i,
   input  logic [DATA_WIDTH-1:0] nextpc_i,
   output logic                  imem_req_valid,
   input  logic                  imem_req_ready,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_rsp_valid,
   input  logic [31:0]           imem_rdata,
   output logic                  if_valid,
   input  logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_pc,
   output logic [31:0]           if_instr
`ifdef RV_IFETCH_MISALIGN_TRAP_EN
   ,
   output logic                  if_trap
`endif
);

   localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0]     DEPTH_L = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0]   MAX_L   = CW'(MAX_OUTST);

   ifetch_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0]  pc_q;
   logic [DATA_WIDTH-1:0]  tag_pc;
   logic [CW-1:0]          outstanding;
   logic [CW-1:0]          fifo_count;
   logic [CW-1:0]          drop_cnt;
   logic                   credit_ok, accept, rsp_take, push, pop, misalign;
   if_entry_t              push_entry, head;

`ifdef RV_IFETCH_MISALIGN_TRAP_EN
   assign misalign = redirect_i && (nextpc_i[1:0] != 2'b00);
`else
   logic unused_bits;
   assign misalign    = 1'b0;
   assign unused_bits = ^{head.trap, nextpc_i[1:0]};
`endif

   // Credits cover both in-flight requests and buffered entries, so a response can always be pushed.
   assign credit_ok = (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_L) && (outstanding < MAX_L);
   assign accept    = imem_req_valid && imem_req_ready;
   assign rsp_take  = imem_rsp_valid && (outstanding != '0);
   assign pop       = if_valid && if_ready;
   assign imem_addr = pc_q;

   always_comb begin
      state_d        = state_q;
      imem_req_valid = 1'b0;
      case (state_q)
         S_BOOT:  state_d = S_RUN;
         S_RUN:   imem_req_valid = credit_ok;
         S_HALT:  if (redirect_i) state_d = S_RUN;
         default: state_d = S_BOOT;
      endcase
      if (misalign) state_d = S_HALT;
   end

   always_comb begin
      push       = rsp_take && (drop_cnt == '0) && !redirect_i;
      push_entry = '{pc: tag_pc, instr: imem_rdata, trap: 1'b0};
      if (misalign) begin
         push       = 1'b1;
         push_entry = '{pc: nextpc_i, instr: RV_NOP, trap: 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_BOOT;
         pc_q     <= RESET_PC;
         drop_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (redirect_i) begin
`ifdef RV_IFETCH_MISALIGN_TRAP_EN
            pc_q <= nextpc_i;
`else
            pc_q <= {nextpc_i[DATA_WIDTH-1:2], 2'b00};
`endif
            // Everything still in flight after this edge belongs to the old path.
            drop_cnt <= outstanding + CW'(accept) - CW'(rsp_take);
         end else begin
            if (accept) pc_q <= pc_q + DATA_WIDTH'(4);
            if (rsp_take && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
         end
      end
   end

   rv_ifetch_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .T          (logic [DATA_WIDTH-1:0])
   ) u_tag (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (1'b0),
      .push       (accept),
      .push_data  (pc_q),
      .pop        (rsp_take),
      .head       (tag_pc),
      .count      (outstanding)
   );

   rv_ifetch_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .T          (if_entry_t)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect_i),
      .push       (push),
      .push_data  (push_entry),
      .pop        (pop),
      .head       (head),
      .count      (fifo_count)
   );

   assign if_valid = (fifo_count != '0);
   assign if_pc    = if_valid ? head.pc    : '0;
   assign if_instr = if_valid ? head.instr : RV_NOP;
`ifdef RV_IFETCH_MISALIGN_TRAP_EN
   assign if_trap  = if_valid && head.trap;
`endif

endmodule

// File: tb/tb_rv_ifetch.sv
// tb/tb_rv_ifetch.sv - scoreboard bench for rv_ifetch; honours RV_IFETCH_MISALIGN_TRAP_EN
module tb_rv_ifetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        trap;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_i = 1'b0;
   logic [31:0] nextpc_i = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        if_valid;
   logic        if_ready = 1'b1;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
`ifdef RV_IFETCH_MISALIGN_TRAP_EN
   logic        if_trap;
`endif

   int          n_checks = 0;
   int          n_fail = 0;
   exp_t        exp_q[$];
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   int          cyc = 0;
   int          lat = 1;
   int          n_acc = 0;
   int          n_pop = 0;
   logic [31:0] exp_addr = '0;
   bit          halted = 0;
   bit          watch = 0;
   bit          last_acc = 0;
   logic [31:0] first_pc = 32'hDEAD_BEEF;
   logic        first_trap = 1'b0;

   rv_ifetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_i     (redirect_i),
      .nextpc_i       (nextpc_i),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_instr       (if_instr)
`ifdef RV_IFETCH_MISALIGN_TRAP_EN
      ,
      .if_trap        (if_trap)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      logic        acc;
      logic [31:0] a;
      exp_t        e;
      @(negedge clk);
      acc = imem_req_valid && imem_req_ready;
      a   = imem_addr;
      last_acc = acc;
      if (if_valid && if_ready) begin
         n_pop++;
         if (exp_q.size() == 0) begin
            check("unexpected_pop", 1'b1, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("if_pc", if_pc, e.pc);
            check("if_instr", if_instr, e.instr);
`ifdef RV_IFETCH_MISALIGN_TRAP_EN
            check("if_trap", if_trap, e.trap);
            if (watch) first_trap = if_trap;
`endif
            if (watch) begin
               first_pc = if_pc;
               watch    = 0;
            end
         end
      end
      if (acc) begin
         n_acc++;
         check("imem_addr", a, exp_addr);
         if (halted) check("req_while_halted", 1'b1, 1'b0);
         exp_q.push_back('{pc: exp_addr, instr: instr_of(exp_addr), trap: 1'b0});
         exp_addr = exp_addr + 32'd4;
         pend_addr.push_back(a);
         pend_due.push_back(cyc + lat);
      end
      if (redirect_i) begin
         exp_q.delete();
         watch    = 1;
         first_pc = 32'hDEAD_BEEF;
`ifdef RV_IFETCH_MISALIGN_TRAP_EN
         if (nextpc_i[1:0] != 2'b00) begin
            exp_q.push_back('{pc: nextpc_i, instr: NOP, trap: 1'b1});
            halted = 1;
         end else begin
            halted   = 0;
            exp_addr = nextpc_i;
         end
`else
         exp_addr = nextpc_i & 32'hFFFF_FFFC;
`endif
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rdata     = instr_of(pend_addr.pop_front());
         void'(pend_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rdata     = '0;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic redirect(input logic [31:0] t);
      redirect_i = 1'b1;
      nextpc_i   = t;
      tick();
      redirect_i = 1'b0;
   endtask

   task automatic drain();
      bit done = 0;
      imem_req_ready = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (exp_q.size() == 0 && pend_due.size() == 0 && !if_valid) begin
            done = 1;
            break;
         end
         tick();
      end
      check("drain_done", done, 1'b1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      pend_addr.delete();
      pend_due.delete();
      imem_rsp_valid = 1'b0;
      halted   = 0;
      exp_addr = 32'h0;
      watch    = 1;
      first_pc = 32'hDEAD_BEEF;
      check("rst_req_valid", imem_req_valid, 1'b0);
      check("rst_imem_addr", imem_addr, 32'h0);
      check("rst_if_valid", if_valid, 1'b0);
      check("rst_if_pc", if_pc, 32'h0);
      check("rst_if_instr", if_instr, NOP);
`ifdef RV_IFETCH_MISALIGN_TRAP_EN
      check("rst_if_trap", if_trap, 1'b0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("boot_no_req", imem_req_valid, 1'b0);
   endtask

   initial begin
      int          n0;
      bit          hit;
      logic [31:0] held;

      @(posedge clk);
      #1;
      do_reset();

      // Straight-line fetch with an ideal imem
      imem_req_ready = 1'b1;
      run(12);
      check("first_pc_reset", first_pc, 32'h0);
      check("t1_progress", n_pop >= 3, 1'b1);

      // Decode stall bounds the number of new requests
      if_ready = 1'b0;
      n0 = n_acc;
      run(10);
      check("stall_acc_bound", (n_acc - n0) <= 2, 1'b1);
      check("stall_if_valid", if_valid, 1'b1);
      if_ready = 1'b1;
      run(8);
      drain();

      // Redirect in the same cycle as the accept at 0x8
      do_reset();
      imem_req_ready = 1'b1;
      hit = 0;
      for (int i = 0; i < 20; i++) begin
         if (imem_req_valid && imem_addr == 32'h8) begin
            hit = 1;
            break;
         end
         tick();
      end
      check("reach_addr8", hit, 1'b1);
      redirect(32'h200);
      check("redir_same_cycle_acc", last_acc, 1'b1);
      run(10);
      drain();
      check("first_pc_0x200", first_pc, 32'h200);

      // Redirect with two requests in flight
      imem_req_ready = 1'b1;
      lat = 3;
      hit = 0;
      for (int i = 0; i < 20; i++) begin
         if (pend_due.size() == 2) begin
            hit = 1;
            break;
         end
         tick();
      end
      check("two_in_flight", hit, 1'b1);
      redirect(32'h100);
      lat = 1;
      run(10);
      drain();
      check("first_pc_0x100", first_pc, 32'h100);

      // Backpressure from imem holds the request, then a redirect withdraws it
      hit = 0;
      for (int i = 0; i < 10; i++) begin
         if (imem_req_valid) begin
            hit = 1;
            break;
         end
         tick();
      end
      check("hold_valid_seen", hit, 1'b1);
      held = imem_addr;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", imem_req_valid, 1'b1);
         check("hold_addr", imem_addr, held);
      end
      redirect(32'h400);
      check("withdraw_addr", imem_addr, 32'h400);
      imem_req_ready = 1'b1;
      run(8);
      drain();
      check("first_pc_0x400", first_pc, 32'h400);

      // Address wrap at the top of the space
      imem_req_ready = 1'b1;
      redirect(32'hFFFF_FFF8);
      run(12);
      drain();
      check("first_pc_wrap", first_pc, 32'hFFFF_FFF8);

`ifdef RV_IFETCH_MISALIGN_TRAP_EN
      imem_req_ready = 1'b1;
      redirect(32'h102);
      n0 = n_acc;
      run(6);
      check("halt_acc", n_acc - n0, 0);
      check("trap_pc", first_pc, 32'h102);
      check("trap_flag", first_trap, 1'b1);
      redirect(32'h300);
      run(8);
      drain();
      check("first_pc_0x300", first_pc, 32'h300);
`else
      imem_req_ready = 1'b1;
      redirect(32'h506);
      run(8);
      drain();
      check("first_pc_aligned", first_pc, 32'h504);
`endif

      // Reset in the middle of traffic
      imem_req_ready = 1'b1;
      lat = 3;
      run(4);
      do_reset();
      lat = 1;
      run(10);
      drain();
      check("first_pc_after_rst", first_pc, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
